// File: rtl/mode_trap_pkg.sv
// Shared constants for the privilege-mode / trap unit: instruction
// encodings recognised at decode, trap cause codes and the FSM state type.
package mode_trap_pkg;

    localparam logic [6:0]  OPCODE_ENTER_USER = 7'b0001011;
    localparam logic [6:0]  OPCODE_SYSTEM     = 7'b1110011;
    localparam logic [11:0] FUNCT12_ECALL     = 12'h000;
    localparam logic [11:0] FUNCT12_MRET      = 12'h302;

    localparam logic [3:0]  CAUSE_ECALL_U     = 4'd8;
    localparam logic [3:0]  CAUSE_ILLEGAL     = 4'd2;

    typedef enum logic [1:0] {
        MACHINE    = 2'd0,
        USER       = 2'd1,
        TRAP_REDIR = 2'd2,
        RET_REDIR  = 2'd3
    } mode_state_t;

endpackage

// File: rtl/mode_trap_unit.sv
// Privilege-mode tracker with trap entry / return redirect handshake.
// Optional feature: define MODE_TRAP_COUNT_EN to add a 32-bit trap_count
// output counting accepted trap redirects.
module mode_trap_unit
    import mode_trap_pkg::*;
#(
    parameter int                      CORE         = 0,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] TRAP_VECTOR  = ADDRESS_BITS'('h00100)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [6:0]              opcode,
    input  logic [11:0]             funct12,
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic                    redirect_ready,
    input  logic                    report,
    output logic                    user_mode,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    stall,
    output logic [ADDRESS_BITS-1:0] epc,
`ifdef MODE_TRAP_COUNT_EN
    output logic [31:0]             trap_count,
`endif
    output logic [3:0]              cause
);

    mode_state_t             state_reg, state_next;
    logic [ADDRESS_BITS-1:0] epc_reg, epc_next;
    logic [3:0]              cause_reg, cause_next;
    logic                    user_mode_reg, user_mode_next;
    logic                    redirect_valid_reg, redirect_valid_next;
    logic [ADDRESS_BITS-1:0] redirect_pc_reg, redirect_pc_next;

    logic is_enter_user, is_ecall, is_mret;

    // Decode the three instructions this unit cares about.
    always_comb begin
        is_enter_user = (opcode == OPCODE_ENTER_USER);
        is_ecall      = (opcode == OPCODE_SYSTEM) && (funct12 == FUNCT12_ECALL);
        is_mret       = (opcode == OPCODE_SYSTEM) && (funct12 == FUNCT12_MRET);
    end

    // State and all registered outputs; reset drops any pending redirect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg          <= MACHINE;
            epc_reg            <= '0;
            cause_reg          <= '0;
            user_mode_reg      <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            epc_reg            <= epc_next;
            cause_reg          <= cause_next;
            user_mode_reg      <= user_mode_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
        end
    end

    // Next state plus trap capture; decode only in MACHINE/USER, handshake only in redirect states.
    always_comb begin
        state_next = state_reg;
        epc_next   = epc_reg;
        cause_next = cause_reg;
        case (state_reg)
            MACHINE: begin
                // ECALL from machine mode is ignored: no nested traps.
                if (valid && is_enter_user) begin
                    state_next = USER;
                end else if (valid && is_mret) begin
                    state_next = RET_REDIR;
                end
            end
            USER: begin
                if (valid && is_ecall) begin
                    state_next = TRAP_REDIR;
                    epc_next   = pc;
                    cause_next = CAUSE_ECALL_U;
                end else if (valid && (is_enter_user || is_mret)) begin
                    state_next = TRAP_REDIR;
                    epc_next   = pc;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            TRAP_REDIR: begin
                if (redirect_ready) state_next = MACHINE;
            end
            RET_REDIR: begin
                if (redirect_ready) state_next = USER;
            end
            default: state_next = MACHINE;
        endcase
    end

    // Output values for the state being entered, so the outputs can be registered.
    always_comb begin
        user_mode_next      = (state_next == USER);
        redirect_valid_next = 1'b0;
        redirect_pc_next    = '0;
        if (state_next == TRAP_REDIR) begin
            redirect_valid_next = 1'b1;
            redirect_pc_next    = TRAP_VECTOR;
        end else if (state_next == RET_REDIR) begin
            redirect_valid_next = 1'b1;
            // Return address wraps at the PC width.
            redirect_pc_next    = epc_next + ADDRESS_BITS'(4);
        end
    end

`ifdef MODE_TRAP_COUNT_EN
    logic [31:0] trap_count_reg;

    // Count accepted trap redirects; wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            trap_count_reg <= '0;
        end else if (state_reg == TRAP_REDIR && redirect_ready) begin
            trap_count_reg <= trap_count_reg + 32'd1;
        end
    end

    assign trap_count = trap_count_reg;
`endif

    // Debug state dump, one line per cycle while report is high.
    always_ff @(posedge clock) begin
        if (report) begin
            $display("core %0d state=%s user_mode=%0b epc=%h cause=%0d",
                     CORE, state_reg.name(), user_mode_reg, epc_reg, cause_reg);
        end
    end

    assign user_mode      = user_mode_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign stall          = redirect_valid_reg;
    assign epc            = epc_reg;
    assign cause          = cause_reg;

endmodule

// File: doc/mode_trap_unit.md
MODE_TRAP_UNIT -- requirements
Module: mode_trap_unit

Interface
REQ-001 The module SHALL have parameter CORE, default 0, core index used in report output.
REQ-002 The module SHALL have parameter ADDRESS_BITS, default 20, PC width.
REQ-003 The module SHALL have parameter TRAP_VECTOR, default 0x00100, handler entry address, ADDRESS_BITS wide.
REQ-004 The module SHALL have port clock, input, 1, sole clock, with all state updated on the rising edge.
REQ-005 The module SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-006 The module SHALL have port valid, input, 1, decode-stage instruction present this cycle.
REQ-007 The module SHALL have port opcode, input, 7, instruction opcode.
REQ-008 The module SHALL have port funct12, input, 12, instruction bits 31:20.
REQ-009 The module SHALL have port pc, input, ADDRESS_BITS, PC of the decode-stage instruction.
REQ-010 The module SHALL have port redirect_ready, input, 1, fetch accepts the redirect.
REQ-011 The module SHALL have port report, input, 1, enables $display state dump.
REQ-012 The module SHALL have port user_mode, output, 1, core is executing in user privilege.
REQ-013 The module SHALL have port redirect_valid, output, 1, PC redirect request.
REQ-014 The module SHALL have port redirect_pc, output, ADDRESS_BITS, redirect target.
REQ-015 The module SHALL have port stall, output, 1, hold decode and flush younger instructions.
REQ-016 The module SHALL have port epc, output, ADDRESS_BITS, saved exception PC.
REQ-017 The module SHALL have port cause, output, 4, last trap cause.

Function
REQ-018 The module SHALL have four states: MACHINE, USER, TRAP_REDIR and RET_REDIR.
REQ-019 The module SHALL decode ENTER_USER as opcode 7'b0001011, ECALL as opcode 7'b1110011 with funct12 0x000, and MRET as opcode 7'b1110011 with funct12 0x302; only inputs sampled with valid=1 in MACHINE or USER are decoded.
REQ-020 In MACHINE, ENTER_USER SHALL cause a move to USER on the next edge, with user_mode=1 from that edge and no redirect.
REQ-021 In USER, ECALL SHALL capture epc<=pc and cause<=8 and move to TRAP_REDIR.
REQ-022 In USER, ENTER_USER or MRET SHALL capture epc<=pc and cause<=2 (illegal) and move to TRAP_REDIR.
REQ-023 In MACHINE, MRET SHALL move to RET_REDIR, leaving epc and cause unchanged.
REQ-024 In MACHINE, ECALL SHALL be ignored; there are no nested traps.
REQ-025 In TRAP_REDIR, the module SHALL drive redirect_valid=1, redirect_pc=TRAP_VECTOR and user_mode=0.
REQ-026 In RET_REDIR, the module SHALL drive redirect_valid=1 and redirect_pc=epc+4, truncated to ADDRESS_BITS so that it wraps.
REQ-027 redirect_valid and redirect_pc SHALL stay stable until the cycle in which redirect_ready=1.
REQ-028 On that handshake edge, TRAP_REDIR SHALL go to MACHINE and RET_REDIR SHALL go to USER, with user_mode=1 on the following cycle.
REQ-029 Latency SHALL be: trigger sampled at edge N, redirect_valid high from N+1, minimum redirect_valid width 1 cycle.
REQ-030 stall SHALL equal redirect_valid.
REQ-031 valid SHALL be ignored in TRAP_REDIR and RET_REDIR.
REQ-032 redirect_ready SHALL be ignored in MACHINE and USER.
REQ-033 user_mode, redirect_valid, epc and cause SHALL be registered outputs.
REQ-034 When report=1, the module SHALL $display CORE, the state, user_mode, epc and cause each cycle.

Reset
REQ-035 With reset=0 at an edge, the module SHALL go to MACHINE with user_mode=0, redirect_valid=0, redirect_pc=0, epc=0 and cause=0.
REQ-036 Reset SHALL override every state, including an in-flight redirect, which is dropped without a handshake.

Configuration
REQ-037 With MODE_TRAP_COUNT_EN defined, the module SHALL add output trap_count, 32 bits, reset to 0, incremented on each TRAP_REDIR handshake and wrapping from 0xFFFFFFFF to 0.
REQ-038 With MODE_TRAP_COUNT_EN undefined, the trap_count port and its counter SHALL be absent.

Structure
REQ-039 Package mode_trap_pkg SHALL hold the opcode and funct12 constants, the cause codes (ECALL_U=8, ILLEGAL=2) and the state encoding.
REQ-040 No sub-module is needed; the block SHALL be one FSM plus its registers.

Verification
REQ-041 The bench SHALL cover: MACHINE, ENTER_USER at pc=0x40 -> user_mode=1 next cycle, redirect_valid stays 0.
REQ-042 The bench SHALL cover: USER, ECALL at pc=0x80, redirect_ready held 0 for 3 cycles -> redirect_valid high 4 cycles at 0x00100, epc=0x80, cause=8, then MACHINE with user_mode=0.
REQ-043 The bench SHALL cover: MACHINE with epc=0x80, MRET, redirect_ready=1 -> redirect_valid for 1 cycle with redirect_pc=0x84, then user_mode=1.
REQ-044 The bench SHALL cover: USER, ENTER_USER at pc=0xC0 -> trap with cause=2 and epc=0xC0.
REQ-045 The bench SHALL cover: epc=0xFFFFC with MRET -> redirect_pc=0x00000.
REQ-046 The bench SHALL cover: reset=0 asserted during TRAP_REDIR -> next cycle MACHINE, all outputs 0; with MODE_TRAP_COUNT_EN, trap_count=0.
